// File: rtl/store_commit_buffer.sv
// Store commit buffer: holds completed stores until the ROB commits them, then
// drains committed stores to data memory one at a time over a we/ack handshake.
//
// state | meaning
// IDLE  | no write in flight; picks the lowest-index committed entry if any
// WRITE | mem_we asserted for entry wr_slot, waiting for mem_ack
module store_commit_buffer #(
    parameter int                  WORD_SIZE = 32,
    parameter int                  RB_INDEX  = 4,
    parameter logic [RB_INDEX-1:0] NULL      = {RB_INDEX{1'b1}},
    parameter int                  DEPTH     = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    input  logic [RB_INDEX-1:0]    st_rb_index,
    input  logic [WORD_SIZE-1:0]   st_addr,
    input  logic [WORD_SIZE-1:0]   st_data,
    output logic                   st_ready,
    input  logic                   commit_valid,
    input  logic [RB_INDEX-1:0]    commit_rb_index,
    output logic                   commit_hit,
    input  logic                   flush,
    output logic                   mem_we,
    output logic [WORD_SIZE-1:0]   mem_addr,
    output logic [WORD_SIZE-1:0]   mem_wdata,
    input  logic                   mem_ack,
    output logic                   done_valid,
    output logic [RB_INDEX-1:0]    done_rb_index,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {
        IDLE,
        WRITE
    } state_t;

    state_t state;

    logic [DEPTH-1:0]     ent_valid;
    logic [DEPTH-1:0]     ent_committed;
    logic [RB_INDEX-1:0]  ent_rb   [DEPTH];
    logic [WORD_SIZE-1:0] ent_addr [DEPTH];
    logic [WORD_SIZE-1:0] ent_data [DEPTH];

    logic [PW-1:0]    wr_slot;
    logic [PW-1:0]    free_slot;
    logic [PW-1:0]    ready_slot;
    logic             ready_any;
    logic [DEPTH-1:0] commit_match;
    logic [CW-1:0]    drop_cnt;

    logic cap_cand;
    logic capture;
    logic bypass;
    logic complete;

    // Scan downward so the lowest index wins for both free and ready picks.
    always_comb begin
        free_slot    = '0;
        ready_slot   = '0;
        ready_any    = 1'b0;
        commit_match = '0;
        drop_cnt     = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                free_slot = PW'(i);
            end
            if (ent_valid[i] && ent_committed[i]) begin
                ready_slot = PW'(i);
                ready_any  = 1'b1;
            end
            commit_match[i] = commit_valid && ent_valid[i] && !ent_committed[i] &&
                              (ent_rb[i] == commit_rb_index);
            if (ent_valid[i] && !ent_committed[i]) begin
                drop_cnt = drop_cnt + CW'(1);
            end
        end
    end

    assign st_ready   = (count != CW'(DEPTH));
    assign cap_cand   = st_valid && st_ready && (st_rb_index != NULL);
    assign capture    = cap_cand && !flush;
    assign bypass     = commit_valid && cap_cand && (st_rb_index == commit_rb_index);
    assign commit_hit = (|commit_match) || bypass;
    assign complete   = (state == WRITE) && mem_ack;

    // The slot being freed by a completion was valid before the edge, so it
    // can never be the free_slot chosen for a same-edge capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid     <= '0;
            ent_committed <= '0;
        end else begin
            if (flush) begin
                ent_valid <= ent_valid & ent_committed;
            end else begin
                ent_committed <= ent_committed | commit_match;
                if (capture) begin
                    ent_valid[free_slot]     <= 1'b1;
                    ent_committed[free_slot] <= bypass;
                end
            end
            if (complete) begin
                ent_valid[wr_slot] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            ent_rb[free_slot]   <= st_rb_index;
            ent_addr[free_slot] <= st_addr;
            ent_data[free_slot] <= st_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            wr_slot       <= '0;
            done_valid    <= 1'b0;
            done_rb_index <= NULL;
        end else begin
            done_valid    <= 1'b0;
            done_rb_index <= NULL;
            case (state)
                IDLE: begin
                    if (ready_any) begin
                        mem_addr  <= ent_addr[ready_slot];
                        mem_wdata <= ent_data[ready_slot];
                        wr_slot   <= ready_slot;
                        mem_we    <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_we        <= 1'b0;
                        done_valid    <= 1'b1;
                        done_rb_index <= ent_rb[wr_slot];
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Capture, completion and flush drop may all land on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CW'(capture) - CW'(complete) - (flush ? drop_cnt : CW'(0));
        end
    end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Bench for store_commit_buffer: directed scenarios plus random traffic, with a
// store-level reference model and a write scoreboard checked by a monitor.
module tb_store_commit_buffer;

    localparam int         DEPTH = 4;
    localparam logic [3:0] NULL  = 4'hF;

    typedef struct {
        logic [3:0]  rb;
        logic [31:0] addr;
        logic [31:0] data;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        st_valid;
    logic [3:0]  st_rb_index;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        commit_valid;
    logic [3:0]  commit_rb_index;
    logic        commit_hit;
    logic        flush;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        done_valid;
    logic [3:0]  done_rb_index;
    logic [2:0]  count;

    store_commit_buffer #(
        .WORD_SIZE(32),
        .RB_INDEX (4),
        .NULL     (NULL),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .st_valid       (st_valid),
        .st_rb_index    (st_rb_index),
        .st_addr        (st_addr),
        .st_data        (st_data),
        .st_ready       (st_ready),
        .commit_valid   (commit_valid),
        .commit_rb_index(commit_rb_index),
        .commit_hit     (commit_hit),
        .flush          (flush),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .done_valid     (done_valid),
        .done_rb_index  (done_rb_index),
        .count          (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: uncommitted stores, committed-but-unwritten stores (commit order),
    // and the scoreboard of writes the monitor expects to see.
    rec_t unc[$];
    rec_t wq[$];
    rec_t exp_q[$];
    logic used[16];

    int          we_cycles  = 0;
    int          done_seen  = 0;
    logic        prev_we    = 1'b0;
    logic        prev_done  = 1'b0;
    logic [31:0] prev_addr  = '0;
    logic [31:0] prev_data  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    function automatic int mcount();
        return unc.size() + wq.size();
    endfunction

    function automatic int find_unc(input logic [3:0] rb);
        for (int i = 0; i < unc.size(); i++) begin
            if (unc[i].rb == rb) return i;
        end
        return -1;
    endfunction

    // Monitor: pops the scoreboard on each completion, checks each new write.
    always @(negedge clk) begin
        rec_t e;
        if (done_valid) begin
            done_seen++;
            check("done_spacing", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
                fail_now("done_unexpected");
            end else begin
                e = exp_q.pop_front();
                check("done_rb_index", 32'(done_rb_index), 32'(e.rb));
            end
        end else begin
            check("done_idle_null", 32'(done_rb_index), 32'(NULL));
        end
        if (mem_we) begin
            we_cycles++;
            if (!prev_we) begin
                if (exp_q.size() == 0) begin
                    fail_now("write_unexpected");
                end else begin
                    check("mem_addr", mem_addr, exp_q[0].addr);
                    check("mem_wdata", mem_wdata, exp_q[0].data);
                end
            end else begin
                check("addr_stable", mem_addr, prev_addr);
                check("data_stable", mem_wdata, prev_data);
            end
        end
        prev_we   = mem_we;
        prev_done = done_valid;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
    end

    // One clock: drive at negedge, check combinational/count outputs against
    // the model, then advance the model across the posedge.
    task automatic cyc(input logic sv, input logic [3:0] srb, input logic [31:0] sa,
                       input logic [31:0] sd, input logic cv, input logic [3:0] crb,
                       input logic fl, input logic ack);
        int   ui;
        logic exp_ready, cap_c, byp, exp_hit, was_we;
        rec_t r;
        st_valid        = sv;
        st_rb_index     = srb;
        st_addr         = sa;
        st_data         = sd;
        commit_valid    = cv;
        commit_rb_index = crb;
        flush           = fl;
        mem_ack         = ack;
        #1;
        exp_ready = (mcount() < DEPTH);
        cap_c     = sv && exp_ready && (srb != NULL);
        ui        = find_unc(crb);
        byp       = cv && cap_c && (srb == crb);
        exp_hit   = cv && ((ui >= 0) || byp);
        check("count", 32'(count), 32'(mcount()));
        check("st_ready", 32'(st_ready), 32'(exp_ready));
        check("commit_hit", 32'(commit_hit), 32'(exp_hit));
        was_we = mem_we;
        @(posedge clk);
        if (ack && was_we && wq.size() > 0) begin
            r = wq.pop_front();
            used[r.rb] = 1'b0;
        end
        if (fl) begin
            foreach (unc[i]) used[unc[i].rb] = 1'b0;
            unc.delete();
        end else begin
            if (exp_hit && ui >= 0) begin
                r = unc[ui];
                unc.delete(ui);
                wq.push_back(r);
                exp_q.push_back(r);
            end
            if (cap_c) begin
                r = '{rb: srb, addr: sa, data: sd};
                used[srb] = 1'b1;
                if (byp) begin
                    wq.push_back(r);
                    exp_q.push_back(r);
                end else begin
                    unc.push_back(r);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic ack);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, ack);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        st_valid        = 1'b0;
        st_rb_index     = 4'd0;
        st_addr         = '0;
        st_data         = '0;
        commit_valid    = 1'b1;
        commit_rb_index = 4'd10;
        flush           = 1'b0;
        mem_ack         = 1'b0;
        @(posedge clk);
        unc.delete();
        wq.delete();
        exp_q.delete();
        for (int i = 0; i < 16; i++) used[i] = 1'b0;
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_done_rb", 32'(done_rb_index), 32'(NULL));
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd1);
        check("rst_commit_hit", 32'(commit_hit), 32'd0);
        reset        = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (wq.size() > 0 && guard < 200) begin
            idle(mem_we);
            guard++;
        end
        if (wq.size() > 0) fail_now("drain_timeout");
        idle(1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        sv, cv, fl, ack;
        logic [3:0]  srb, crb;
        int          r, d0;

        do_reset();

        // Single store with two wait cycles before the ack.
        we_cycles = 0;
        done_seen = 0;
        cyc(1'b1, 4'd3, 32'h40, 32'h1234, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);
        check("single_we_cycles", 32'(we_cycles), 32'd3);
        check("single_done_count", 32'(done_seen), 32'd1);

        // Fill to DEPTH, refuse a fifth, free one slot and refill it.
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 4'(i), 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 1'b0, 4'd0, 1'b0, 1'b0);
        end
        check("full_st_ready", 32'(st_ready), 32'd0);
        cyc(1'b1, 4'd8, 32'h200, 32'hBB, 1'b0, 4'd0, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd4);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd0, 1'b0, 1'b0);
        idle(1'b0);
        cyc(1'b1, 4'd9, 32'h300, 32'hCC, 1'b0, 4'd0, 1'b0, 1'b1);
        check("refill_st_ready", 32'(st_ready), 32'd1);
        cyc(1'b1, 4'd9, 32'h300, 32'hCC, 1'b0, 4'd0, 1'b0, 1'b0);
        check("refill_count", 32'(count), 32'd4);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("flush_all_count", 32'(count), 32'd0);

        // Out-of-order commit and an absent RB index.
        cyc(1'b1, 4'd5, 32'h500, 32'h55, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd2, 32'h220, 32'h22, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd2, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 1'b0);
        drain();
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 1'b0);
        drain();

        // Capture and commit of the same store in one cycle.
        cyc(1'b1, 4'd6, 32'h600, 32'h66, 1'b1, 4'd6, 1'b0, 1'b0);
        idle(1'b0);
        check("bypass_we", 32'(mem_we), 32'd1);
        drain();

        // Flush keeps the in-flight committed write, drops the rest.
        d0 = done_seen;
        cyc(1'b1, 4'd1, 32'h110, 32'h11, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b1, 4'd4, 32'h440, 32'h44, 1'b1, 4'd1, 1'b0, 1'b0);
        cyc(1'b1, 4'd5, 32'h550, 32'h55, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        check("flush_count", 32'(count), 32'd1);
        idle(1'b1);
        for (int i = 0; i < 5; i++) idle(1'b0);
        check("flush_done_count", 32'(done_seen - d0), 32'd1);

        // Reset in the middle of a write.
        cyc(1'b1, 4'd10, 32'hA00, 32'hAA, 1'b1, 4'd10, 1'b0, 1'b0);
        idle(1'b0);
        check("prereset_we", 32'(mem_we), 32'd1);
        do_reset();
        idle(1'b0);

        // Random traffic; commits limited so the write order is commit order.
        for (int n = 0; n < 600; n++) begin
            sv  = ($urandom_range(0, 9) < 6);
            srb = 4'd0;
            if (sv) begin
                if ($urandom_range(0, 19) == 0) begin
                    srb = NULL;
                end else begin
                    srb = 4'($urandom_range(0, 14));
                    while (used[srb]) srb = 4'($urandom_range(0, 14));
                end
            end
            cv  = 1'b0;
            crb = 4'd0;
            r   = $urandom_range(0, 9);
            if (wq.size() <= 1 && r < 4) begin
                cv = 1'b1;
                if (r < 2 && unc.size() > 0) begin
                    crb = unc[$urandom_range(0, unc.size() - 1)].rb;
                end else if (r == 2 && sv) begin
                    crb = srb;
                end else begin
                    crb = 4'($urandom_range(0, 15));
                    while (find_unc(crb) >= 0 || (sv && crb == srb)) crb = 4'($urandom_range(0, 15));
                end
            end
            fl  = ($urandom_range(0, 24) == 0);
            ack = mem_we && ($urandom_range(0, 1) == 1);
            cyc(sv, srb, $urandom(), $urandom(), cv, crb, fl, ack);
        end
        drain();
        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
